// File: rtl/counter_slot_pkg.sv
// counter_slot_pkg: state encoding, default sizes and length-decode convention for the slot arbiter
package counter_slot_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_COUNT = ST_COUNT,
    S_DONE = ST_DONE
  } state_t;
  // A length field of zero stands for the full 2^w cycles.
  function automatic int slot_len(input int unsigned l, input int w);
    return l == 0 ? 2 ** w : int'(l);
  endfunction
endpackage

// File: rtl/sync_counter_ce.sv
// sync_counter_ce: synchronous up-counter with clear (priority) and count enable
module sync_counter_ce #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= (rst || clr) ? '0 : en ? q + W'(1) : q;
endmodule

// File: rtl/counter_slot_arbiter.sv
// counter_slot_arbiter: round-robin arbiter granting timed slots on one shared counter
module counter_slot_arbiter
  import counter_slot_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] len,
  output logic [N_REQ-1:0]       gnt,
  output logic [1:0]             owner,
  output logic                   busy,
  output logic [N_REQ-1:0]       done,
  output logic [CNT_W-1:0]       q
);
  state_t state, nxt;
  logic [1:0] ptr, win;
  logic [CNT_W-1:0] len_r;
  logic abort, term;

  sync_counter_ce #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state == S_LOAD),
    .en (state == S_COUNT),
    .q  (q)
  );

  // Scan downward so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    win = ptr;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[ptr + 2'(k)]) win = ptr + 2'(k);
  end

  assign abort = ~req[owner];
  assign term  = q == len_r - CNT_W'(1);
  assign busy  = state != S_IDLE;

  always_comb begin
    nxt = state == S_IDLE  ? (|req ? S_LOAD : S_IDLE) :
          state == S_LOAD  ? S_COUNT :
          state == S_COUNT ? (abort ? S_IDLE : term ? S_DONE : S_COUNT) :
          S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      len_r <= '0;
      done  <= '0;
    end else begin
      state <= nxt;
      done  <= '0;
      if (state == S_IDLE && |req) begin
        gnt   <= N_REQ'(1) << win;
        owner <= win;
        len_r <= len[win*CNT_W +: CNT_W];
      end
      if (state == S_COUNT && nxt != S_COUNT) gnt <= '0;
      if (state == S_COUNT && nxt == S_DONE) done <= N_REQ'(1) << owner;
      if ((state == S_COUNT && abort) || state == S_DONE) ptr <= owner + 2'd1;
    end
  end
endmodule

// File: doc/counter_slot_arbiter.md
# counter_slot_arbiter

Round-robin arbiter and sequencer that shares one 3-bit synchronous up-counter among four requesters. Each requester asks for a timed slot of 1–8 clock cycles. The block grants one requester at a time, clears and runs the shared counter for the requested length, then pulses a per-requester done. It sits between the requesting control logic and the counter datapath, and it is the only block that drives the counter's clear and enable.

## Interface
Parameters:
- N_REQ, 4, number of requesters; fixed at 4 in this revision.
- CNT_W, 3, width of the shared counter and of each length field.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  level request per requester; bit i is requester i.
- len  input  N_REQ*CNT_W  slot length per requester; len[3i+2:3i] belongs to requester i; value 0 means 8 cycles.
- gnt  output  N_REQ  registered one-hot grant; all zero when no slot is active.
- owner  output  2  index of the current or last grantee.
- busy  output  1  high in every state except IDLE.
- done  output  N_REQ  one-cycle pulse on the bit of a slot that completed normally.
- q  output  CNT_W  shared counter value.

## Operation
The FSM has four states: IDLE, LOAD, COUNT, DONE.

IDLE
- req is sampled only in this state.
- If any req bit is set, the winner is the first set bit searching from ptr upward, modulo 4.
- Next state is LOAD. On that edge gnt takes the winner's one-hot value, owner takes its index, and len_r latches len of the winner.

LOAD
- Lasts one cycle. The counter is cleared, so q = 0 on the next edge.
- Next state is COUNT.

COUNT
- The counter increments every cycle.
- Terminal condition: q == len_r − 1, computed in CNT_W bits. With len_r = 0 this compares against 7, giving 8 cycles.
- When the terminal condition is met, the next state is DONE.
- Abort: if req[owner] is low during any COUNT cycle, the next state is IDLE. gnt clears and no done pulse is issued.

DONE
- Lasts one cycle. done[owner] = 1 and gnt = 0.
- Next state is IDLE.

Pointer update
- ptr ← owner + 1 (mod 4) on both DONE exit and abort.

Counter behaviour
- q holds its value in DONE and IDLE.
- q wraps 7→0 only by arithmetic. Wrap cannot occur within a slot, because the terminal condition always fires at 7 or earlier.

Simultaneous events and rule precedence
- New requests arriving in LOAD, COUNT or DONE wait for IDLE.
- If the terminal condition and an abort occur in the same cycle, abort wins: no done pulse.
- A change on len after the IDLE→LOAD edge has no effect on the running slot.

Reset
- rst has priority over every state, including mid-COUNT.
- Reset values: state = IDLE, gnt = 0, owner = 0, busy = 0, done = 0, q = 0, ptr = 0, len_r = 0.
- An aborted slot caused by reset produces no done pulse.

## Timing
- Request to grant: req seen in IDLE at cycle t gives gnt at t+1 (LOAD).
- COUNT occupies cycles t+2 … t+1+L, where L = len (8 if len = 0). q shows 0 … L−1 over those cycles.
- done is high at t+2+L. IDLE follows at t+3+L.
- A slot of length L occupies L+3 cycles from LOAD entry through the IDLE cycle.
- Back-to-back grants: the next grant appears at earliest one IDLE cycle after DONE.
- All outputs are registered. There are no combinational paths from req or len to any output.

## Structure
Shared package `counter_slot_pkg` holds:
- the state encoding constants ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_COUNT = 2'd2, ST_DONE = 2'd3;
- the defaults for N_REQ and CNT_W;
- the length-decode convention (0 means 2^CNT_W).

One sub-module, `sync_counter_ce`, is the CNT_W-bit synchronous up-counter:
- ports clk, rst, clr, en, q;
- clr has priority over en;
- the arbiter drives clr = (state == LOAD) and en = (state == COUNT).

The top level contains the FSM, the round-robin pointer, the one-hot grant register, len_r and the terminal compare.

## Test plan
- Single request, L = 3: req = 0001, len0 = 3 at cycle 0 → gnt = 0001 at cycle 1; q = 0, 1, 2 at cycles 2–4; done = 0001 at cycle 5; busy low at cycle 6.
- Full length, len = 0: req = 0100, len2 = 0 → q = 0 … 7 over 8 COUNT cycles; done = 0100 nine cycles after LOAD. No extra wrap cycle.
- Contention: req = 1111 held, all lengths = 1 → grant order 0, 1, 2, 3, 0; ptr advances after each DONE; no double grant.
- Abort: requester 1 with len = 5 drops req at q = 2 → next cycle state = IDLE, gnt = 0, no done; ptr = 2.
- Reset mid-COUNT: rst = 1 at q = 4 for requester 3 → next edge gives all outputs 0 and state IDLE; after rst falls, req = 1111 grants requester 0 (ptr = 0).
- Late arrival: req0 granted with len = 4; req2 rises during COUNT → req2 is granted only in the IDLE cycle after done0 (gnt = 0100 at done0 + 2).
